// File: rtl/finv_seq.sv
// Newton-Raphson reciprocal sequencer: time-multiplexes one external fmul and one
// external fadd through ITER iterations of x <= x*(2 - s*x).
module finv_seq #(
  parameter int ITER  = 6,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] s,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d,
  output logic        div0,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_y,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_y
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL1 = 3'd1,
    ADD  = 3'd2,
    MUL2 = 3'd3,
    ZERO = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);
  localparam logic [31:0]      FP_TWO   = 32'h4000_0000;

  state_t            state_reg, state_next;
  logic [31:0]       s_reg, x_reg, a_reg, c_reg, d_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              div0_reg;
  logic              accept;

  assign accept = in_valid && (state_reg == IDLE);
  assign d      = d_reg;
  assign div0   = div0_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Shared-unit operands come from state and registers only, so the external
  // combinational units can never close a loop through this block.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    mul_a      = 32'h0;
    mul_b      = 32'h0;
    add_a      = 32'h0;
    add_b      = 32'h0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = (s[30:23] == 8'd0) ? ZERO : MUL1;
        end
      end
      MUL1: begin
        mul_a      = s_reg;
        mul_b      = x_reg;
        state_next = ADD;
      end
      ADD: begin
        add_a      = FP_TWO;
        add_b      = {~a_reg[31], a_reg[30:0]};
        state_next = MUL2;
      end
      MUL2: begin
        mul_a      = c_reg;
        mul_b      = x_reg;
        state_next = (cnt_reg == LAST_CNT) ? DONE : MUL1;
      end
      ZERO: begin
        state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_reg    <= 32'h0;
      x_reg    <= 32'h0;
      a_reg    <= 32'h0;
      c_reg    <= 32'h0;
      d_reg    <= 32'h0;
      cnt_reg  <= '0;
      div0_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            s_reg   <= s;
            // Seed: exponent reflected around the bias, mantissa dropped.
            x_reg   <= {s[31], 8'd253 - s[30:23], 23'b0};
            cnt_reg <= '0;
          end
        end
        MUL1: a_reg <= mul_y;
        ADD:  c_reg <= add_y;
        MUL2: begin
          x_reg <= mul_y;
          if (cnt_reg == LAST_CNT) begin
            d_reg <= mul_y;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ZERO: begin
          d_reg    <= {s_reg[31], 8'hFF, 23'b0};
          div0_reg <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            div0_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
